frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader_if.sv | 28 ++
 rtl/frame_loader.sv | 75 +++++++
 tb/tb_frame_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_if.sv
// Pixel-stream and frame-RAM write bundle for frame_loader.
// The loader sits on the slave side; the source/RAM environment sits on the master side.
interface frame_loader_if #(
  parameter int PIXEL_DEPTH = 8
);
  logic                     pix_valid;
  logic [3*PIXEL_DEPTH-1:0] pix_data;
  logic                     pix_sof;
  logic                     pix_ready;
  logic                     ram_busy;
  logic                     wr_en;
  logic [14:0]              wr_addr;
  logic [6*PIXEL_DEPTH-1:0] wr_data;
  logic [1:0]               wr_be;
  logic [3:0]               img_idx;
  logic                     frame_done;
  logic                     frame_err;

  modport master (
    output pix_valid, pix_data, pix_sof, ram_busy,
    input  pix_ready, wr_en, wr_addr, wr_data, wr_be, img_idx, frame_done, frame_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, ram_busy,
    output pix_ready, wr_en, wr_addr, wr_data, wr_be, img_idx, frame_done, frame_err
  );
endinterface

// File: rtl/frame_loader.sv
// Streams a 64x32 image into a dual-half frame RAM: rows 0-15 go to the upper lane,
// rows 16-31 to the lower lane of the same word, one image slot per frame.
module frame_loader #(
  parameter int PIXEL_DEPTH  = 8,
  parameter int PANEL_WIDTH  = 64,
  parameter int PANEL_HEIGHT = 32,
  parameter int NUM_IMAGES   = 12
) (
  input  logic          clk,
  input  logic          rst,
  frame_loader_if.slave bus
);
  localparam int         DATA_W   = 3 * PIXEL_DEPTH;
  localparam logic [10:0] LAST_PIX = 11'(PANEL_WIDTH * PANEL_HEIGHT - 1);
  localparam logic [3:0]  LAST_IMG = 4'(NUM_IMAGES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [10:0]       pix_cnt;
  logic [10:0]       idx;
  logic [DATA_W-1:0] pixel;
  logic              xfer;
  logic              accept;
  logic              restart;
  logic              hold;

  assign bus.pix_ready = !rst && !bus.ram_busy;

  // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    pixel   = bus.pix_data;
    xfer    = bus.pix_valid && bus.pix_ready;
    hold    = bus.wr_en && bus.ram_busy;
    accept  = xfer && (state == RUN || bus.pix_sof);
    restart = xfer && bus.pix_sof && (state == RUN) && (pix_cnt != '0);
    idx     = bus.pix_sof ? '0 : pix_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pix_cnt        <= '0;
      bus.img_idx    <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.wr_be      <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.frame_err  <= restart;

      // A stalled write cannot be overwritten: ram_busy also drops pix_ready, so accept is 0.
      if (!hold) bus.wr_en <= accept;

      if (accept) begin
        bus.wr_addr <= {bus.img_idx, 1'b0, idx[9:6], idx[5:0]};
        bus.wr_data <= {pixel, pixel};
        bus.wr_be   <= idx[10] ? 2'b01 : 2'b10;
        if (idx == LAST_PIX) begin
          state          <= IDLE;
          pix_cnt        <= '0;
          bus.frame_done <= 1'b1;
          bus.img_idx    <= (bus.img_idx == LAST_IMG) ? '0 : bus.img_idx + 4'd1;
        end else begin
          state   <= RUN;
          pix_cnt <= idx + 11'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: directed scenario sequence with randomized
// gaps, data and RAM stalls, checked each cycle against a behavioural frame model.
module tb_frame_loader;
  localparam int PD    = 8;
  localparam int FRAME = 2048;
  localparam int NIMG  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_loader_if #(.PIXEL_DEPTH(PD)) bus ();

  frame_loader #(
    .PIXEL_DEPTH (PD),
    .PANEL_WIDTH (64),
    .PANEL_HEIGHT(32),
    .NUM_IMAGES  (NIMG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observed RAM-side activity.
  int dut_writes = 0;
  int dut_done   = 0;
  int dut_errs   = 0;
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1 && bus.ram_busy === 1'b0) dut_writes <= dut_writes + 1;
    if (bus.frame_done === 1'b1) dut_done <= dut_done + 1;
    if (bus.frame_err === 1'b1)  dut_errs <= dut_errs + 1;
  end

  // Reference model: frame position, slot number and the pending RAM write.
  bit          m_in_frame = 1'b0;
  int          m_p        = 0;
  int          m_img      = 0;
  logic        m_wr_en    = 1'b0;
  logic        m_done     = 1'b0;
  logic        m_err      = 1'b0;
  logic [14:0] m_addr     = '0;
  logic [47:0] m_data     = '0;
  logic [1:0]  m_be       = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, predict, check after the rising edge.
  task automatic step(input bit v, input bit sof, input bit busy, input logic [23:0] d,
                      output bit xfer);
    int idx;
    bit hold;
    bit acc;
    @(negedge clk);
    bus.pix_valid = v;
    bus.pix_sof   = sof;
    bus.ram_busy  = busy;
    bus.pix_data  = d;
    #1;
    check("pix_ready", 64'(bus.pix_ready), 64'(!rst && !busy));
    xfer   = v && !busy && !rst;
    hold   = (m_wr_en == 1'b1) && busy;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_in_frame = 1'b0;
      m_p        = 0;
      m_img      = 0;
      m_wr_en    = 1'b0;
    end else begin
      acc = xfer && (m_in_frame || sof);
      if (acc) begin
        if (sof && m_in_frame) m_err = 1'b1;
        idx    = sof ? 0 : m_p;
        m_addr = 15'(m_img * FRAME + idx % 1024);
        m_be   = (idx < 1024) ? 2'b10 : 2'b01;
        m_data = {d, d};
        if (idx == FRAME - 1) begin
          m_done     = 1'b1;
          m_in_frame = 1'b0;
          m_p        = 0;
          m_img      = (m_img + 1) % NIMG;
        end else begin
          m_in_frame = 1'b1;
          m_p        = idx + 1;
        end
      end
      if (!hold) m_wr_en = acc;
    end
    @(posedge clk);
    #1;
    check("wr_en",      64'(bus.wr_en),      64'(m_wr_en));
    check("frame_done", 64'(bus.frame_done), 64'(m_done));
    check("frame_err",  64'(bus.frame_err),  64'(m_err));
    check("img_idx",    64'(bus.img_idx),    64'(m_img));
    if (m_wr_en) begin
      check("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
      check("wr_data", 64'(bus.wr_data), 64'(m_data));
      check("wr_be",   64'(bus.wr_be),   64'(m_be));
    end
  endtask

  // Send count pixels; with gaps, insert random idle cycles and random RAM stalls.
  task automatic send_pixels(input int count, input bit sof_first, input bit gaps);
    bit x;
    for (int p = 0; p < count; p++) begin
      if (gaps && $urandom_range(7) == 0)
        step(1'b0, 1'b0, $urandom_range(7) == 0, 24'($urandom), x);
      x = 1'b0;
      for (int t = 0; t < 8 && !x; t++)
        step(1'b1, sof_first && p == 0, gaps && t < 3 && $urandom_range(7) == 0,
             {8'(p), 16'($urandom)}, x);
    end
  endtask

  task automatic drain();
    bit x;
    step(1'b0, 1'b0, 1'b0, 24'h0, x);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   64'(bus.wr_en),      64'(0));
    check({tag, "_wr_addr"}, 64'(bus.wr_addr),    64'(0));
    check({tag, "_wr_data"}, 64'(bus.wr_data),    64'(0));
    check({tag, "_wr_be"},   64'(bus.wr_be),      64'(0));
    check({tag, "_done"},    64'(bus.frame_done), 64'(0));
    check({tag, "_err"},     64'(bus.frame_err),  64'(0));
    check({tag, "_img"},     64'(bus.img_idx),    64'(0));
  endtask

  initial begin
    bit x;
    int base;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.ram_busy  = 1'b0;
    bus.pix_data  = '0;

    // Reset state.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 24'h0, x);
    step(1'b1, 1'b1, 1'b0, 24'h123456, x);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 24'h0, x);

    // Pixels without SOF while idle are discarded.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 24'($urandom), x);
    check("idle_no_write", 64'(dut_writes), 64'(0));

    // Image 0: contiguous, R = p[7:0], with one 3-cycle RAM stall.
    for (int p = 0; p < FRAME; p++) begin
      step(1'b1, p == 0, 1'b0, {8'(p), 16'($urandom)}, x);
      if (p == 0)    check("first_addr",  64'(bus.wr_addr), 64'(15'h0000));
      if (p == 64)   check("row1_addr",   64'(bus.wr_addr), 64'(15'h0040));
      if (p == 64)   check("row1_be",     64'(bus.wr_be),   64'(2'b10));
      if (p == 1024) check("row16_addr",  64'(bus.wr_addr), 64'(15'h0000));
      if (p == 1024) check("row16_be",    64'(bus.wr_be),   64'(2'b01));
      if (p == 300) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b1, 1'b0, 1'b1, 24'($urandom), x);
          check("stall_no_xfer", 64'(x),           64'(0));
          check("stall_addr",    64'(bus.wr_addr), 64'(15'h012C));
          check("stall_wr_en",   64'(bus.wr_en),   64'(1));
        end
      end
    end
    drain();
    check("img0_writes", 64'(dut_writes), 64'(FRAME));
    check("img0_done",   64'(dut_done),   64'(1));
    check("img0_idx",    64'(bus.img_idx), 64'(1));

    // Images 1..12 with random gaps and stalls; the 13th lands back in slot 0.
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) begin
        send_pixels(1, 1'b1, 1'b0);
        check("wrap_slot_addr", 64'(bus.wr_addr), 64'(15'h0000));
        send_pixels(FRAME - 1, 1'b0, 1'b1);
      end else begin
        send_pixels(FRAME, 1'b1, 1'b1);
      end
      drain();
      check("frame_idx",    64'(bus.img_idx), 64'((k + 1) % NIMG));
      check("frame_count",  64'(dut_done),    64'(k + 1));
      check("frame_writes", 64'(dut_writes),  64'(FRAME * (k + 1)));
    end

    // Early SOF at p=100 aborts and restarts the image in the same slot.
    send_pixels(100, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 24'hABCDEF, x);
    check("err_pulse",   64'(bus.frame_err), 64'(1));
    check("err_addr",    64'(bus.wr_addr),   64'(15'h0800));
    check("err_img_idx", 64'(bus.img_idx),   64'(1));
    drain();
    check("err_one_cycle", 64'(bus.frame_err), 64'(0));
    base = dut_done;
    send_pixels(FRAME - 2, 1'b0, 1'b1);
    drain();
    check("err_no_early_done", 64'(dut_done), 64'(base));
    send_pixels(1, 1'b0, 1'b0);
    drain();
    check("err_late_done", 64'(dut_done),    64'(base + 1));
    check("err_errs",      64'(dut_errs),    64'(1));
    check("err_next_idx",  64'(bus.img_idx), 64'(2));

    // Reset mid-frame at p=500.
    send_pixels(500, 1'b1, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 24'($urandom), x);
    check_reset_outputs("midrst");
    rst = 1'b0;
    send_pixels(1, 1'b1, 1'b0);
    check("post_rst_addr", 64'(bus.wr_addr), 64'(15'h0000));
    check("post_rst_img",  64'(bus.img_idx), 64'(0));
    base = dut_done;
    send_pixels(FRAME - 1, 1'b0, 1'b0);
    drain();
    check("post_rst_done", 64'(dut_done),    64'(base + 1));
    check("post_rst_idx",  64'(bus.img_idx), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
